systolic_ctrl: RTL and testbench

- Sequencer for the DIMxDIM systolic MAC array.
- Runs one matrix-multiply pass per `start`:
  - clears the C accumulators row by row;
  - steps the skewed A/B feed index while driving the array `en`;
  - reads the DIM result rows out over a valid/ready handshake.
- Sits between the command interface and the array plus its A/B skew buffers. Owns the array's `en`, `WrEn` and `Crow` inputs.

---
 rtl/systolic_ctrl_if.sv | 48 ++++
 rtl/systolic_ctrl.sv | 128 ++++++++++++
 tb/tb_systolic_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - Command, array-control and result-handshake bundle for systolic_ctrl.
// perf_cycles/perf_stalls exist only when SYSTOLIC_CTRL_PERF_EN is defined.
interface systolic_ctrl_if #(
  parameter int DIM   = 8,
  parameter int CNT_W = $clog2(3*DIM)
);
  localparam int ROW_W = $clog2(DIM);

  logic             start;
  logic             feed_stall;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             arr_en;
  logic             arr_wren;
  logic [ROW_W-1:0] arr_crow;
  logic             clr_c;
  logic [CNT_W-1:0] feed_idx;
  logic             feed_valid;
  logic             out_valid;
  logic [ROW_W-1:0] out_row;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]      perf_cycles;
  logic [31:0]      perf_stalls;

  modport master (
    input  start, feed_stall, out_ready,
    output busy, done, arr_en, arr_wren, arr_crow, clr_c,
           feed_idx, feed_valid, out_valid, out_row, perf_cycles, perf_stalls
  );
  modport slave (
    output start, feed_stall, out_ready,
    input  busy, done, arr_en, arr_wren, arr_crow, clr_c,
           feed_idx, feed_valid, out_valid, out_row, perf_cycles, perf_stalls
  );
`else
  modport master (
    input  start, feed_stall, out_ready,
    output busy, done, arr_en, arr_wren, arr_crow, clr_c,
           feed_idx, feed_valid, out_valid, out_row
  );
  modport slave (
    output start, feed_stall, out_ready,
    input  busy, done, arr_en, arr_wren, arr_crow, clr_c,
           feed_idx, feed_valid, out_valid, out_row
  );
`endif
endinterface

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - Clear/compute/read sequencer for a DIMxDIM systolic MAC array.
// Define SYSTOLIC_CTRL_PERF_EN to add the perf_cycles/perf_stalls counters.
module systolic_ctrl #(
  parameter int DIM   = 8,
  parameter int CNT_W = $clog2(3*DIM)
) (
  input  logic               clk,
  input  logic               rst_n,
  systolic_ctrl_if.master    bus
);
  localparam int ROW_W = $clog2(DIM);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_READ    = 2'd3;

  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(3*DIM - 3);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == ROW_LAST) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        // A stalled step is replayed, so the index only moves when the feed is available.
        if (!bus.feed_stall) begin
          if (cnt_q == STEP_LAST) begin
            state_d = S_READ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_READ: begin
        if (bus.out_ready) begin
          if (cnt_q == ROW_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.arr_en     = (state_q == S_COMPUTE) && !bus.feed_stall;
  assign bus.arr_wren   = (state_q == S_CLEAR);
  assign bus.clr_c      = (state_q == S_CLEAR);
  assign bus.arr_crow   = (state_q == S_CLEAR || state_q == S_READ) ? cnt_q[ROW_W-1:0] : '0;
  assign bus.feed_valid = (state_q == S_COMPUTE);
  assign bus.feed_idx   = (state_q == S_COMPUTE) ? cnt_q : '0;
  assign bus.out_valid  = (state_q == S_READ);
  assign bus.out_row    = (state_q == S_READ) ? cnt_q[ROW_W-1:0] : '0;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        perf_cycles_d = '0;
        perf_stalls_d = '0;
      end
    end else begin
      if (!(&perf_cycles_q)) perf_cycles_d = perf_cycles_q + 32'd1;
      if (state_q == S_COMPUTE && bus.feed_stall && !(&perf_stalls_q))
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - Directed bench for systolic_ctrl with a progress-counting reference model.
// Perf counter checks are compiled in when SYSTOLIC_CTRL_PERF_EN is defined.
module tb_systolic_ctrl;
  localparam int DIM   = 8;
  localparam int CNT_W = $clog2(3*DIM);
  localparam int ROW_W = $clog2(DIM);
  localparam int NSTEP = 3*DIM - 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.DIM(DIM), .CNT_W(CNT_W)) bus ();
  systolic_ctrl #(.DIM(DIM), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_count = 0, last_done_cyc = -1000;
  int en_cnt = 0, wren_cnt = 0, fv_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        done_count++;
        last_done_cyc = cyc;
      end
      if (bus.arr_en) en_cnt++;
      if (bus.arr_wren) wren_cnt++;
      if (bus.feed_valid) fv_cnt++;
    end
  end

  // Reference model: tracks how far the pass has progressed (rows cleared, steps fed, rows read).
  bit m_act = 0, m_done = 0;
  int m_cleared = 0, m_steps = 0, m_rows = 0;
  int m_pc = 0, m_ps = 0;

  always @(negedge clk) begin
    logic e_busy, e_done, e_en, e_wren, e_clr, e_fv, e_ov;
    logic [ROW_W-1:0] e_crow, e_row;
    logic [CNT_W-1:0] e_idx;
    logic [17:0] act_v, exp_v;
    bit in_clear, in_comp, in_read;
    in_clear = m_act && (m_cleared < DIM);
    in_comp  = m_act && !in_clear && (m_steps < NSTEP);
    in_read  = m_act && !in_clear && !in_comp;
    e_busy = m_act;
    e_done = m_done;
    e_wren = in_clear;
    e_clr  = in_clear;
    e_fv   = in_comp;
    e_en   = in_comp && !bus.feed_stall;
    e_ov   = in_read;
    e_crow = in_clear ? ROW_W'(m_cleared) : (in_read ? ROW_W'(m_rows) : '0);
    e_row  = in_read ? ROW_W'(m_rows) : '0;
    e_idx  = in_comp ? CNT_W'(m_steps) : '0;
    if (!rst_n) begin
      e_busy = 0; e_done = 0; e_wren = 0; e_clr = 0; e_fv = 0; e_en = 0; e_ov = 0;
      e_crow = '0; e_row = '0; e_idx = '0;
    end
    act_v = {bus.busy, bus.done, bus.arr_en, bus.arr_wren, bus.clr_c, bus.feed_valid,
             bus.out_valid, bus.arr_crow, bus.feed_idx, bus.out_row};
    exp_v = {e_busy, e_done, e_en, e_wren, e_clr, e_fv, e_ov, e_crow, e_idx, e_row};
    chk($sformatf("outputs@cyc%0d", cyc), act_v, exp_v);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk($sformatf("perf_cycles@cyc%0d", cyc), bus.perf_cycles, rst_n ? m_pc : 0);
    chk($sformatf("perf_stalls@cyc%0d", cyc), bus.perf_stalls, rst_n ? m_ps : 0);
`endif
    if (!rst_n) begin
      m_act = 0; m_done = 0; m_cleared = 0; m_steps = 0; m_rows = 0; m_pc = 0; m_ps = 0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (bus.start) begin
          m_act = 1; m_cleared = 0; m_steps = 0; m_rows = 0; m_pc = 0; m_ps = 0;
        end
      end else begin
        m_pc++;
        if (in_clear) m_cleared++;
        else if (in_comp) begin
          if (bus.feed_stall) m_ps++;
          else m_steps++;
        end else if (bus.out_ready) begin
          m_rows++;
          if (m_rows == DIM) begin
            m_act = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_now(output int t);
    bus.start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic start_pass(output int t);
    @(posedge clk); #1;
    start_now(t);
  endtask

  task automatic wait_done(input string name, input int target, input int t0, input int exp_lat);
    int n = 0;
    while (done_count < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, last_done_cyc - t0, exp_lat);
  endtask

  int t0, t1, dones;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.feed_stall = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    dones = 0;

    // Nominal pass
    en_cnt = 0; wren_cnt = 0; fv_cnt = 0;
    start_pass(t0);
    dones++;
    wait_done("nominal_done_latency", dones, t0, 39);
    chk("nominal_en_cycles", en_cnt, 22);
    chk("nominal_wren_cycles", wren_cnt, 8);

    // Three-cycle feed stall at feed_idx 5
    en_cnt = 0; fv_cnt = 0;
    start_pass(t0);
    wait_cyc(t0 + 14);
    bus.feed_stall = 1'b1;
    @(negedge clk);
    chk("stall_idx_held", bus.feed_idx, 5);
    chk("stall_en_low", bus.arr_en, 0);
    wait_cyc(t0 + 17);
    bus.feed_stall = 1'b0;
    dones++;
    wait_done("stall_done_latency", dones, t0, 42);
    chk("stall_compute_cycles", fv_cnt, 25);
    chk("stall_en_cycles", en_cnt, 22);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("stall_perf_cycles", bus.perf_cycles, 41);
    chk("stall_perf_stalls", bus.perf_stalls, 3);
`endif

    // Backpressure on result row 2
    start_pass(t0);
    wait_cyc(t0 + 33);
    bus.out_ready = 1'b0;
    wait_cyc(t0 + 35);
    @(negedge clk);
    chk("bp_row_held", bus.out_row, 2);
    chk("bp_valid_held", bus.out_valid, 1);
    wait_cyc(t0 + 37);
    bus.out_ready = 1'b1;
    dones++;
    wait_done("bp_done_latency", dones, t0, 43);

    // Stray start pulses in CLEAR, COMPUTE and READ
    start_pass(t0);
    wait_cyc(t0 + 3);  start_now(t1);
    wait_cyc(t0 + 15); start_now(t1);
    wait_cyc(t0 + 33); start_now(t1);
    dones++;
    wait_done("stray_done_latency", dones, t0, 39);
    repeat (60) @(posedge clk);
    #1;
    chk("stray_single_done", done_count, dones);
    chk("stray_idle_after", bus.busy, 0);

    // Reset during COMPUTE at feed_idx 10
    start_pass(t0);
    wait_cyc(t0 + 19);
    #1;
    chk("rst_idx_before", bus.feed_idx, 10);
    rst_n = 1'b0;
    #1;
    chk("rst_en_drop", bus.arr_en, 0);
    chk("rst_fv_drop", bus.feed_valid, 0);
    chk("rst_busy_drop", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("rst_no_done", done_count, dones);
    start_pass(t0);
    dones++;
    wait_done("rst_recover_latency", dones, t0, 39);

    // Back-to-back: restart in the done cycle
    start_pass(t0);
    wait_cyc(t0 + 39);
    bus.start = 1'b1;
    t1 = cyc;
    @(negedge clk);
    chk("b2b_done_first", bus.done, 1);
    chk("b2b_idle_in_done", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_clear_next", bus.arr_wren, 1);
    dones += 2;
    wait_done("b2b_second_latency", dones, t1, 39);
    chk("b2b_done_count", done_count, dones);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
